// File: rtl/aes_round_ctrl_pkg.sv
// Shared constants and state encoding for the AES-128 round controller,
// key-expansion and datapath blocks.
package aes_ctrl_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int AES_RND_W     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Request/status bundle between the AES round controller (slave) and the
// block that requests encryptions and consumes the ciphertext (master).
interface aes_round_ctrl_if
    import aes_ctrl_pkg::*;
#(
    parameter int CNT_W = AES_RND_W
);

    logic             start;
    logic             abort;
    logic             out_ack;
    logic             busy;
    logic             load_state;
    logic             round_en;
    logic             key_step;
    logic             last_round;
    logic [CNT_W-1:0] round_idx;
    logic             done;
    logic             out_valid;

    modport master (
        output start, abort, out_ack,
        input  busy, load_state, round_en, key_step, last_round,
               round_idx, done, out_valid
    );

    modport slave (
        input  start, abort, out_ack,
        output busy, load_state, round_en, key_step, last_round,
               round_idx, done, out_valid
    );

endinterface

// File: rtl/aes_round_ctrl_rise_detect.sv
// Registered one-shot rising-edge detector. The previous-sample flop resets
// to 1 so a level already high when reset releases is not seen as an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // Track the input level every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: one run per start edge,
// LOAD -> (NUM_ROUNDS-1) x ROUND -> FINAL -> DONE, result held until acked.
// Every output is a flop decoded from the next state, so no input reaches an
// output combinationally.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int CNT_W      = AES_RND_W
) (
    input  logic            clk,
    input  logic            rst,
    aes_round_ctrl_if.slave ctl
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] FINAL_IDX = CNT_W'(NUM_ROUNDS);

    if (NUM_ROUNDS < 2 || NUM_ROUNDS > 15 || (2 ** CNT_W) <= NUM_ROUNDS) begin : g_param_check
        $error("aes_round_ctrl: NUM_ROUNDS must be 2..15 and fit in CNT_W bits");
    end

    aes_state_e       state_q, state_d;
    logic [CNT_W-1:0] round_idx_q, round_idx_d;
    logic             busy_q, busy_d;
    logic             load_q, load_d;
    logic             step_q, step_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             start_edge;

    rise_detect u_start_rise (
        .clk    (clk),
        .rst_n  (rst),
        .d_i    (ctl.start),
        .rise_o (start_edge)
    );

    // Next state, round counter and Moore output decode of the next state.
    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        case (state_q)
            IDLE: begin
                round_idx_d = '0;
                if (start_edge && !ctl.abort) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ctl.abort) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end else begin
                    state_d     = (NUM_ROUNDS == 1) ? FINAL : ROUND;
                    round_idx_d = CNT_W'(1);
                end
            end
            ROUND: begin
                if (ctl.abort) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end else if (round_idx_q == LAST_IDX) begin
                    state_d     = FINAL;
                    round_idx_d = FINAL_IDX;
                end else begin
                    round_idx_d = round_idx_q + CNT_W'(1);
                end
            end
            FINAL: begin
                if (ctl.abort) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end else begin
                    state_d     = DONE;
                    round_idx_d = FINAL_IDX;
                end
            end
            DONE: begin
                // Abort in DONE simply releases the result like an ack.
                if (ctl.out_ack || ctl.abort) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                round_idx_d = '0;
            end
        endcase

        busy_d  = (state_d == LOAD) || (state_d == ROUND) || (state_d == FINAL);
        load_d  = (state_d == LOAD);
        step_d  = (state_d == ROUND) || (state_d == FINAL);
        last_d  = (state_d == FINAL);
        valid_d = (state_d == DONE);
        done_d  = (state_d == DONE) && (state_q != DONE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            round_idx_q <= '0;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            step_q      <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            busy_q      <= busy_d;
            load_q      <= load_d;
            step_q      <= step_d;
            last_q      <= last_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
        end
    end

    assign ctl.busy       = busy_q;
    assign ctl.load_state = load_q;
    assign ctl.round_en   = step_q;
    assign ctl.key_step   = step_q;
    assign ctl.last_round = last_q;
    assign ctl.round_idx  = round_idx_q;
    assign ctl.done       = done_q;
    assign ctl.out_valid  = valid_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. Cycle c is the clock period that
// follows rising edge c; the start edge of a run is sampled at edge s.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    localparam int N   = AES128_ROUNDS;
    localparam int BIG = 100000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_round_ctrl_if #(.CNT_W(AES_RND_W)) bus ();

    aes_round_ctrl #(
        .NUM_ROUNDS (N),
        .CNT_W      (AES_RND_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    // {busy, load_state, round_en, key_step, last_round, out_valid, done, round_idx}
    wire [10:0] obs = {bus.busy, bus.load_state, bus.round_en, bus.key_step,
                       bus.last_round, bus.out_valid, bus.done, bus.round_idx};

    logic [10:0] sb_q[$];
    logic [10:0] expv;
    int          tests_run = 0;
    int          fails     = 0;
    int          dones;

    // Expected outputs in cycle c for a run whose start edge is sampled at
    // edge s and which is released (ack/abort applied) during cycle stop.
    function automatic logic [10:0] exp_at(int c, int s, int stop);
        logic       b, l, r, f, v, d;
        logic [3:0] idx;
        int         p;
        b = 0; l = 0; r = 0; f = 0; v = 0; d = 0; idx = 4'd0;
        p = c - s;
        if (c > s && c <= stop) begin
            if (p == 1) begin
                b = 1; l = 1; idx = 4'd0;
            end else if (p <= N) begin
                b = 1; r = 1; idx = 4'(p - 1);
            end else if (p == N + 1) begin
                b = 1; r = 1; f = 1; idx = 4'(N);
            end else begin
                v = 1; d = (p == N + 2); idx = 4'(N);
            end
        end
        return {b, l, r, r, f, v, d, idx};
    endfunction

    task automatic settle();
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.out_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.out_ack = 1'b0;
        rst         = 1'b0;
        #2;
        tests_run++;
        if (obs !== 11'b0) begin
            fails++;
            $display("FAIL reset_state: got %b want %b", obs, 11'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            sb_q.push_back(11'b0);
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL reset_start_held cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
    endtask

    task automatic test_normal_run();
        settle();
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            bus.start = 1'b1;
            sb_q.push_back(exp_at(c + 1, 0, BIG));
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            dones += int'(bus.done);
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL normal_run cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        tests_run++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL normal_run_done_count: got %0d want 1", dones);
        end
        bus.out_ack = 1'b1;
        @(posedge clk); #1;
        bus.out_ack = 1'b0;
        tests_run++;
        if (obs !== 11'b0) begin
            fails++;
            $display("FAIL normal_run_ack_release: got %b want %b", obs, 11'b0);
        end
    endtask

    task automatic test_ack();
        settle();
        for (int c = 0; c < 27; c++) begin
            bus.start   = (c != 16);
            bus.out_ack = (c == 15);
            bus.abort   = (c == 23);
            if (c + 1 <= 17) sb_q.push_back(exp_at(c + 1, 0, 15));
            else             sb_q.push_back(exp_at(c + 1, 17, 23));
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL ack_restart cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        bus.out_ack = 1'b0;
        bus.abort   = 1'b0;
    endtask

    task automatic test_abort();
        settle();
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            bus.start = 1'b1;
            bus.abort = (c == 5);
            sb_q.push_back(exp_at(c + 1, 0, 5));
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            dones += int'(bus.done);
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL abort_run cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        bus.abort = 1'b0;
        tests_run++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL abort_done_count: got %0d want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        settle();
        dones = 0;
        for (int c = 0; c < 22; c++) begin
            bus.start   = (c != 5);
            bus.out_ack = (c == 8) || (c == 20);
            sb_q.push_back(exp_at(c + 1, 0, 20));
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            dones += int'(bus.done);
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL restart_ignored cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        bus.out_ack = 1'b0;
        tests_run++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL restart_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_abort_start_idle();
        settle();
        for (int c = 0; c < 6; c++) begin
            bus.start = 1'b1;
            bus.abort = (c == 0);
            sb_q.push_back(11'b0);
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL abort_beats_start cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_async_reset();
        settle();
        for (int c = 0; c < 4; c++) begin
            bus.start = 1'b1;
            sb_q.push_back(exp_at(c + 1, 0, BIG));
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL areset_prerun cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (obs !== 11'b0) begin
            fails++;
            $display("FAIL areset_immediate: got %b want %b", obs, 11'b0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sb_q.push_back(11'b0);
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL areset_idle cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        for (int c = 0; c < 4; c++) begin
            bus.start = 1'b1;
            bus.abort = (c == 1);
            sb_q.push_back(exp_at(c + 1, 0, 1));
            @(posedge clk); #1;
            expv = sb_q.pop_front();
            tests_run++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL areset_rerun cycle %0d: got %b want %b", c + 1, obs, expv);
            end
        end
        bus.abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_ack();
        test_abort();
        test_back_to_back();
        test_abort_start_idle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
